// File: rtl/sccb_cam_responder_pkg.sv
// Shared types and constants for the SCCB camera-config responder.
// Holds the FSM state encoding, the special register addresses and the
// register-file default value helper.
package sccb_resp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_DEV_ADDR = 4'd1,
      ST_DEV_ACK  = 4'd2,
      ST_REG_ADDR = 4'd3,
      ST_REG_ACK  = 4'd4,
      ST_WR_DATA  = 4'd5,
      ST_WR_ACK   = 4'd6,
      ST_RD_DATA  = 4'd7,
      ST_RD_ACK   = 4'd8,
      ST_IGNORE   = 4'd9
   } sccb_state_t;

   localparam logic [7:0] REG_PID       = 8'h0A;
   localparam logic [7:0] REG_VER       = 8'h0B;
   localparam logic [7:0] REG_COM7      = 8'h12;
   localparam int         COM7_SRST_BIT = 7;

   // Power-on / soft-reset contents of one register.
   function automatic logic [7:0] reg_default(input logic [7:0] addr,
                                              input logic [7:0] pid,
                                              input logic [7:0] ver);
      logic [7:0] val;
      case (addr)
         REG_PID: val = pid;
         REG_VER: val = ver;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/sccb_cam_responder_if.sv
// SCCB bus bundle: the two sampled lines plus the open-drain SDA pull-down.
// The master side drives the line levels, the slave side pulls SDA low.
interface sccb_cam_responder_if;
   logic scl_in;
   logic sda_in;
   logic sda_oe;

   modport master (output scl_in, output sda_in, input  sda_oe);
   modport slave  (input  scl_in, input  sda_in, output sda_oe);
endinterface

// File: rtl/sccb_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizers, optional 3-sample agreement
// filter (enabled by SCCB_RESP_GLITCH_FILTER_EN), and detection of SCL
// rise/fall plus bus START/STOP conditions.
module sccb_line_cond (
   input  logic clk,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_c_s;
   logic       sda_c_s;
   logic       scl_dly_q;
   logic       sda_dly_q;

   // Free-running synchronizers: they keep tracking the pins through reset so
   // that leaving reset mid-transfer cannot fabricate a START edge.
   always_ff @(posedge clk) begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
   end

`ifdef SCCB_RESP_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q;
   logic [1:0] sda_hist_q;
   logic       scl_hold_q;
   logic       sda_hold_q;

   assign scl_c_s = (scl_sync_q[1] == scl_hist_q[0] && scl_sync_q[1] == scl_hist_q[1])
                    ? scl_sync_q[1] : scl_hold_q;
   assign sda_c_s = (sda_sync_q[1] == sda_hist_q[0] && sda_sync_q[1] == sda_hist_q[1])
                    ? sda_sync_q[1] : sda_hold_q;

   // Sample history and held level: a line only moves after 3 agreeing samples.
   always_ff @(posedge clk) begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_hold_q <= scl_c_s;
      sda_hold_q <= sda_c_s;
   end
`else
   assign scl_c_s = scl_sync_q[1];
   assign sda_c_s = sda_sync_q[1];
`endif

   // One-cycle delayed copies used for edge detection.
   always_ff @(posedge clk) begin
      scl_dly_q <= scl_c_s;
      sda_dly_q <= sda_c_s;
   end

   assign sda_o      = sda_c_s;
   assign scl_rise_o = scl_c_s & ~scl_dly_q;
   assign scl_fall_o = ~scl_c_s & scl_dly_q;
   assign start_o    = sda_dly_q & ~sda_c_s & scl_c_s & scl_dly_q;
   assign stop_o     = ~sda_dly_q & sda_c_s & scl_c_s & scl_dly_q;
endmodule

// File: rtl/sccb_cam_responder.sv
// OV7670-style SCCB configuration target: 256x8 register file, auto-increment
// pointer, read-only PID/VER, COM7 soft reset, and a commit strobe port.
// Optional input glitch filter: define SCCB_RESP_GLITCH_FILTER_EN.
module sccb_cam_responder
   import sccb_resp_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h21,
   parameter logic [7:0] PID_VAL  = 8'h76,
   parameter logic [7:0] VER_VAL  = 8'h73
) (
   input  logic                 clk,
   input  logic                 reset,
   sccb_cam_responder_if.slave  bus,
   output logic                 wr_strobe,
   output logic [7:0]           wr_addr,
   output logic [7:0]           wr_data,
   output logic                 busy,
   input  logic [7:0]           dbg_addr,
   output logic [7:0]           dbg_data
);
   logic        sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
   sccb_state_t state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        rw_q, rw_d;
   logic        commit_s;
   logic [7:0]  commit_byte_s;
   logic [7:0]  rd_byte_s;
   logic        wr_strobe_q;
   logic [7:0]  wr_addr_q, wr_data_q;
   logic        srst_pend_q;
   logic [7:0]  regs_q [256];

   sccb_line_cond u_line_cond (
      .clk        (clk),
      .scl_i      (bus.scl_in),
      .sda_i      (bus.sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise_s),
      .scl_fall_o (scl_fall_s),
      .start_o    (start_s),
      .stop_o     (stop_s)
   );

   assign commit_byte_s = {shift_q[6:0], sda_s};
   assign rd_byte_s     = regs_q[ptr_q];

   // Protocol FSM next-state: START/STOP override everything, else per-state bit handling.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      rw_d      = rw_q;
      commit_s  = 1'b0;
      if (start_s) begin
         state_d   = ST_DEV_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b1;
      end else if (stop_s) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
               if (scl_rise_s && bit_cnt_q != 4'd8) begin
                  shift_d   = commit_byte_s;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (state_q == ST_WR_DATA && bit_cnt_q == 4'd7) begin
                     commit_s = 1'b1;
                     ptr_d    = ptr_q + 8'd1;
                  end else begin
                     commit_s = 1'b0;
                  end
               end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
                  if (state_q == ST_DEV_ADDR) begin
                     if (shift_q[7:1] == DEV_ADDR) begin
                        sda_oe_d = 1'b1;
                        rw_d     = shift_q[0];
                        state_d  = ST_DEV_ACK;
                     end else begin
                        state_d  = ST_IGNORE;
                     end
                  end else if (state_q == ST_REG_ADDR) begin
                     sda_oe_d = 1'b1;
                     ptr_d    = shift_q;
                     state_d  = ST_REG_ACK;
                  end else begin
                     sda_oe_d = 1'b1;
                     state_d  = ST_WR_ACK;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_DEV_ACK: begin
               if (scl_fall_s) begin
                  if (rw_q) begin
                     // Release ACK and present the first read bit on the same edge.
                     sda_oe_d  = ~rd_byte_s[7];
                     bit_cnt_d = 4'd1;
                     state_d   = ST_RD_DATA;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_REG_ADDR;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_REG_ACK, ST_WR_ACK: begin
               if (scl_fall_s) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
                  state_d   = ST_WR_DATA;
               end else begin
                  state_d = state_q;
               end
            end
            ST_RD_DATA: begin
               if (scl_fall_s) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d  = ~rd_byte_s[3'd7 - bit_cnt_q[2:0]];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise_s) begin
                  if (!sda_s) begin
                     ptr_d     = ptr_q + 8'd1;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_RD_DATA;
                  end else begin
                     state_d   = ST_IGNORE;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_IDLE, ST_IGNORE: begin
               state_d = state_q;
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // Control and output registers, with commit strobe and soft-reset request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         ptr_q       <= 8'h00;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 8'h00;
         wr_data_q   <= 8'h00;
         srst_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         rw_q        <= rw_d;
         wr_strobe_q <= commit_s;
         if (commit_s) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= commit_byte_s;
         end
         srst_pend_q <= commit_s && (ptr_q == REG_COM7) && commit_byte_s[COM7_SRST_BIT];
      end
   end

   // Register file: defaults on reset or COM7 soft reset, else committed writes except PID/VER.
   always_ff @(posedge clk) begin
      if (!reset || srst_pend_q) begin
         for (int i = 0; i < 256; i++) begin
            regs_q[i] <= reg_default(8'(i), PID_VAL, VER_VAL);
         end
      end else if (commit_s && ptr_q != REG_PID && ptr_q != REG_VER) begin
         regs_q[ptr_q] <= commit_byte_s;
      end
   end

   assign bus.sda_oe = sda_oe_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign dbg_data   = regs_q[dbg_addr];
endmodule

// File: tb/tb_sccb_cam_responder.sv
// Self-checking bench for sccb_cam_responder: a bit-banged SCCB master with an
// open-drain SDA model, and a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_sccb_cam_responder;
   typedef logic [7:0] bq_t [$];
   localparam int Q = 6;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       reset;
   logic       m_scl, m_sda;
   logic       wr_strobe, busy;
   logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mregs [256];
   logic [7:0]  mptr;
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];

   sccb_cam_responder_if bus();
   assign bus.scl_in = m_scl;
   assign bus.sda_in = m_sda & ~bus.sda_oe;

   sccb_cam_responder dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) got_q.push_back({wr_addr, wr_data});
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 256; i++)
         mregs[i] = (i == 10) ? 8'h76 : ((i == 11) ? 8'h73 : 8'h00);
   endtask

   task automatic model_wr_byte(input logic [7:0] d);
      exp_q.push_back({mptr, d});
      if (mptr != 8'h0A && mptr != 8'h0B) mregs[mptr] = d;
      if (mptr == 8'h12 && d[7]) model_reset();
      mptr = mptr + 8'd1;
   endtask

   // ---------------- bus master ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(4*Q);
   endtask

   task automatic send_bit(input logic b);
      tick(Q); m_sda = b; tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
      acked = bus.sda_oe;
      tick(Q); m_scl = 1'b0;
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] b);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
         b = {b[6:0], bus.sda_in};
         tick(Q); m_scl = 1'b0;
      end
      send_bit(~ack);
   endtask

   // ---------------- transactions with checks ----------------
   task automatic wr_txn(input logic [7:0] dev, input bq_t data, input string name);
      logic        a;
      logic [15:0] acks, exp_acks;
      bit          match;
      match = (dev[7:1] == 7'h21) && !dev[0];
      acks  = 16'h0000;
      bus_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
      end
      send_byte(dev, a); acks[0] = a;
      foreach (data[i]) begin
         send_byte(data[i], a); acks[i+1] = a;
      end
      bus_stop();
      exp_acks = match ? ((16'd1 << (data.size() + 1)) - 16'd1) : 16'd0;
      if (match) begin
         foreach (data[i]) begin
            if (i == 0) mptr = data[0];
            else model_wr_byte(data[i]);
         end
      end
      n_checks++;
      if (acks !== exp_acks) begin
         n_fail++; $display("FAIL %s ack_slots: got %h expected %h", name, acks, exp_acks);
      end
      n_checks++;
      if (busy !== 1'b0 || bus.sda_oe !== 1'b0) begin
         n_fail++; $display("FAIL %s idle_after_stop: busy=%b sda_oe=%b expected 0 0", name, busy, bus.sda_oe);
      end
   endtask

   task automatic rd_txn(input int n, input string name);
      logic       a;
      logic [7:0] b, expv;
      bus_start();
      send_byte(8'h43, a);
      n_checks++;
      if (a !== 1'b1) begin
         n_fail++; $display("FAIL %s read_dev_ack: got %b expected 1", name, a);
      end
      for (int k = 0; k < n; k++) begin
         recv_byte(k != n - 1, b);
         expv = mregs[mptr];
         n_checks++;
         if (b !== expv) begin
            n_fail++; $display("FAIL %s read_byte%0d: got %h expected %h", name, k, b, expv);
         end
         if (k != n - 1) mptr = mptr + 8'd1;
      end
      bus_stop();
      n_checks++;
      if (busy !== 1'b0 || bus.sda_oe !== 1'b0) begin
         n_fail++; $display("FAIL %s idle_after_read: busy=%b sda_oe=%b expected 0 0", name, busy, bus.sda_oe);
      end
   endtask

   task automatic check_strobes(input string name);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL %s strobe_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL %s strobe%0d addr/data: got %h expected %h", name, i, got_q[i], exp_q[i]);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reg(input logic [7:0] addr, input string name);
      dbg_addr = addr;
      tick(1);
      n_checks++;
      if (dbg_data !== mregs[addr]) begin
         n_fail++; $display("FAIL %s reg[%h]: got %h expected %h", name, addr, dbg_data, mregs[addr]);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; m_scl = 1'b1; m_sda = 1'b1; dbg_addr = 8'h00;
      tick(10);
      reset = 1'b1;
      tick(4);
      model_reset(); mptr = 8'h00;
      n_checks++;
      if (bus.sda_oe !== 1'b0 || wr_strobe !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset outputs: sda_oe=%b wr_strobe=%b busy=%b expected 0 0 0", bus.sda_oe, wr_strobe, busy);
      end
      n_checks++;
      if (wr_addr !== 8'h00 || wr_data !== 8'h00) begin
         n_fail++; $display("FAIL reset wr_addr/wr_data: got %h/%h expected 00/00", wr_addr, wr_data);
      end
      check_reg(8'h0A, "reset");
      check_reg(8'h0B, "reset");
      check_reg(8'h40, "reset");
      check_reg(8'h12, "reset");
      got_q.delete();
   endtask

   task automatic test_write_basic();
      wr_txn(8'h42, '{8'h40, 8'hD0}, "write_basic");
      check_strobes("write_basic");
      check_reg(8'h40, "write_basic");
   endtask

   task automatic test_read_id();
      wr_txn(8'h42, '{8'h0A}, "read_id_setptr");
      check_strobes("read_id_setptr");
      rd_txn(1, "read_id");
      rd_txn(2, "read_id_pair");
   endtask

   task automatic test_addr_mismatch();
      logic [6:0] d;
      wr_txn(8'h60, '{8'h40, 8'h99}, "mismatch60");
      do d = 7'($urandom_range(0, 127)); while (d == 7'h21);
      wr_txn({d, 1'b0}, '{8'h41, 8'($urandom_range(0, 255))}, "mismatch_rand");
      check_strobes("mismatch");
      check_reg(8'h40, "mismatch");
      check_reg(8'h41, "mismatch");
   endtask

   task automatic test_burst_wrap();
      wr_txn(8'h42, '{8'hFF, 8'h11, 8'h22}, "burst_wrap");
      check_strobes("burst_wrap");
      check_reg(8'hFF, "burst_wrap");
      check_reg(8'h00, "burst_wrap");
   endtask

   task automatic test_ro_regs();
      wr_txn(8'h42, '{8'h0A, 8'h55, 8'h66}, "ro_regs");
      check_strobes("ro_regs");
      check_reg(8'h0A, "ro_regs");
      check_reg(8'h0B, "ro_regs");
   endtask

   task automatic test_soft_reset();
      wr_txn(8'h42, '{8'h40, 8'hD0}, "srst_preload");
      wr_txn(8'h42, '{8'h12, 8'h80}, "srst");
      check_strobes("srst");
      check_reg(8'h40, "srst");
      check_reg(8'h12, "srst");
      check_reg(8'h0A, "srst");
   endtask

   task automatic test_reset_mid();
      logic a;
      bus_start();
      send_byte(8'h42, a);
      send_byte(8'h40, a);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.sda_oe !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid outputs: sda_oe=%b busy=%b expected 0 0", bus.sda_oe, busy);
      end
      tick(3);
      reset = 1'b1;
      model_reset(); mptr = 8'h00;
      tick(Q); m_scl = 1'b0;
      send_bit(1'b1); send_bit(1'b0);
      bus_stop();
      check_strobes("reset_mid");
      check_reg(8'h40, "reset_mid");
      wr_txn(8'h42, '{8'h40, 8'h55}, "after_reset");
      check_strobes("after_reset");
      check_reg(8'h40, "after_reset");
   endtask

   task automatic test_random();
      bq_t d;
      for (int it = 0; it < 8; it++) begin
         d.delete();
         d.push_back(8'($urandom_range(0, 255)));
         for (int k = 0; k < int'($urandom_range(1, 3)); k++)
            d.push_back(8'($urandom_range(0, 255)));
         wr_txn(8'h42, d, "rand_write");
         check_strobes("rand_write");
         rd_txn(int'($urandom_range(1, 3)), "rand_read");
      end
      for (int i = 0; i < 256; i++) check_reg(8'(i), "rand_sweep");
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_id();
      test_addr_mismatch();
      test_burst_wrap();
      test_ro_regs();
      test_soft_reset();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sccb_cam_responder.md
Name: sccb_cam_responder

Overview:
- Synthesizable SCCB/I2C target that emulates the OV7670 configuration port: the responder end of the camera-config master's scl/sda bus.
- Used for on-board loopback and bench checking of the camera-init sequence without a sensor attached.
- Runs on the system clock, oversamples SCL/SDA, holds a 256x8 register file, and reports every committed write on a strobe port.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target address (0x42 write / 0x43 read).
- PID_VAL, 8'h76, read-only value of reg 0x0A.
- VER_VAL, 8'h73, read-only value of reg 0x0B.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- reset  in  1  synchronous reset, active-low. reset=0 at a clk rising edge resets the block.
- scl_in  in  1  bus SCL, asynchronous.
- sda_in  in  1  bus SDA, asynchronous.
- sda_oe  out  1  1 pulls SDA low (open-drain); 0 releases it.
- wr_strobe  out  1  one-cycle pulse when a data byte is committed.
- wr_addr  out  8  register address of the committed byte.
- wr_data  out  8  committed data byte.
- busy  out  1  1 from START until STOP.
- dbg_addr  in  8  debug read address.
- dbg_data  out  8  combinational regs[dbg_addr].

Behaviour:
- Reset: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, pointer=0. Regs reset to 0x00, except 0x0A=PID_VAL and 0x0B=VER_VAL.
- Input path: 2-flop synchronizer on scl/sda, then a 1-cycle delayed copy for edge detection.
  - START = SDA falls while SCL=1. STOP = SDA rises while SCL=1.
- Bit timing: sample SDA on the SCL rising edge. Change sda_oe only on the SCL falling edge, at most 4 clk after the pin edge.
- States:
  - IDLE
  - DEV_ADDR: shift 8 bits, MSB first.
  - DEV_ACK: on address match, drive ACK; then go to REG_ADDR if R/W=0 or RD_DATA if R/W=1. On mismatch, go to IGNORE with no ACK.
  - REG_ADDR: shift 8 bits, then REG_ACK (always ACK); pointer := byte.
  - WR_DATA: shift 8 bits, then WR_ACK.
    - At the 8th rising edge: commit regs[pointer], pulse wr_strobe, pointer++.
    - Stay in write mode for bursts.
  - RD_DATA: on each falling edge, sda_oe = ~regs[pointer][bit], MSB first.
    - After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the master bit. ACK(0): pointer++, back to RD_DATA. NACK(1): IGNORE.
  - IGNORE: drive nothing; wait for START or STOP.
- ACK drive: assert sda_oe on the falling edge after the 8th bit; release on the next falling edge.
- START in any state (repeated start): go to DEV_ADDR, bit_cnt=0, sda_oe=0, pointer unchanged.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded and not committed.
- Pointer is 8-bit and wraps 0xFF -> 0x00.
- Writes to 0x0A/0x0B: ACKed and strobed, but the register is unchanged.
- Soft reset: a write of reg 0x12 with bit7=1 restores all regs to reset defaults on the cycle after commit. Reg 0x12 then reads 0x00.
  - wr_strobe still reports the written data (0x12, 0x80).
- Synchronous reset mid-transaction: sda_oe=0 on the next clk edge and all reset values apply. Bus activity up to the next START is ignored.
- wr_strobe and regs commit on the same clk. A dbg_addr read of the same address returns the new value on the cycle after the strobe.

Optional Feature:
- Macro: SCCB_RESP_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a 3-sample agreement filter. The line updates only when 3 consecutive samples match, adding 2 clk of latency. Pulses of 2 clk or shorter are rejected.
- Undefined: 2-flop synchronizer only; a 1-clk glitch may register as an edge.

Decomposition:
- Package sccb_resp_pkg holds:
  - state enum sccb_state_t;
  - constants REG_PID=8'h0A, REG_VER=8'h0B, REG_COM7=8'h12, COM7_SRST_BIT=7.
- One natural sub-module, sccb_line_cond: synchronizer, optional filter, and START/STOP/rise/fall detection for both lines.

Test Plan:
- Write 0x42,0x40,0xD0, STOP -> three ACKs (sda_oe=1 in each ACK slot); wr_strobe once with wr_addr=0x40, wr_data=0xD0; dbg_data@0x40=0xD0.
- Write 0x42,0x0A, STOP; then START,0x43, NACK, STOP -> responder shifts 0x76; sda_oe=0 after STOP; busy=0.
- Address 0x60 then 8 bits -> no ACK; no wr_strobe; regs unchanged until the next START with 0x42.
- Burst 0x42,0xFF,0x11,0x22 -> regs[0xFF]=0x11, regs[0x00]=0x22 (wrap); two strobes.
- Write 0x12=0x80 after preloading 0x40=0xD0 -> regs[0x40]=0x00, regs[0x12]=0x00, regs[0x0A]=0x76.
- reset=0 during the 4th data bit of a write -> next clk sda_oe=0, busy=0, no strobe, target reg unchanged. Then a 0x42,0x40,0x55 transaction succeeds.
